// File: rtl/bcd_display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit common-segment 7-segment
// display. Shows one BCD digit at a time with an optional dark guard gap before
// each digit. Blanks leading zeros on request. New digit values are double-buffered
// so a frame is never torn.
module bcd_display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    lz_suppress,
    output logic [3:0]              bcd_num,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam bit HAS_GUARD = (BLANK_CYCLES > 0);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = HAS_GUARD ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_SHOW
    } state_t;

    // State that follows a finished digit (or a start from idle).
    localparam state_t AFTER_DIGIT = HAS_GUARD ? ST_GUARD : ST_SHOW;

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic [CW-1:0]           r_cnt;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pend_vld;
    logic [3:0]              r_bcd_num;
    logic [NUM_DIGITS-1:0]   r_digit_en;
    logic                    r_frame_done;

    state_t                  w_state_nxt;
    logic [IW-1:0]           w_idx_nxt;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_frame_end;
    logic                    w_digit_entry;
    logic [4*NUM_DIGITS-1:0] w_shadow_nxt;
    logic [4*NUM_DIGITS-1:0] w_pending_nxt;
    logic                    w_pend_vld_nxt;
    logic [3:0]              w_disp;
    logic [NUM_DIGITS-1:0]   w_en_nxt;

    // Scan sequencing: next state, digit index and dwell counter.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_frame_end   = 1'b0;
        w_digit_entry = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = AFTER_DIGIT;
                    w_digit_entry = !HAS_GUARD;
                end
                ST_GUARD: begin
                    if (r_cnt == GUARD_LAST) begin
                        w_cnt_nxt     = '0;
                        w_state_nxt   = ST_SHOW;
                        w_digit_entry = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_cnt_nxt     = '0;
                        w_state_nxt   = AFTER_DIGIT;
                        w_digit_entry = !HAS_GUARD;
                        if (r_idx == LAST_IDX) begin
                            w_frame_end = 1'b1;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Double buffering: direct capture when idle, otherwise park in pending until the frame boundary.
    always_comb begin
        w_shadow_nxt   = r_shadow;
        w_pending_nxt  = r_pending;
        w_pend_vld_nxt = r_pend_vld;
        if (r_state == ST_IDLE) begin
            if (load) w_shadow_nxt = digits_in;
        end else if (w_frame_end) begin
            w_pend_vld_nxt = 1'b0;
            if (load)            w_shadow_nxt = digits_in;
            else if (r_pend_vld) w_shadow_nxt = r_pending;
        end else if (load) begin
            w_pending_nxt  = digits_in;
            w_pend_vld_nxt = 1'b1;
        end
    end

    // Digit value for the upcoming index, with leading-zero blanking from the most significant end.
    always_comb begin
        logic all_zero;
        logic blank;
        logic [3:0] digit;
        all_zero = 1'b1;
        blank    = 1'b0;
        digit    = 4'h0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (w_shadow_nxt[4*i +: 4] == 4'h0);
            if (w_idx_nxt == IW'(i)) begin
                digit = w_shadow_nxt[4*i +: 4];
                blank = lz_suppress && (i != 0) && all_zero;
            end
        end
        w_disp = blank ? 4'hF : digit;
    end

    assign w_en_nxt = (w_state_nxt == ST_SHOW) ? (NUM_DIGITS'(1) << w_idx_nxt) : '0;

    // State, buffers and registered outputs. bcd_num is captured only on digit entry so it
    // stays constant for as long as its strobe is on (lz_suppress is sampled at that point).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_pending    <= '0;
            r_pend_vld   <= 1'b0;
            r_bcd_num    <= 4'hF;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shadow     <= w_shadow_nxt;
            r_pending    <= w_pending_nxt;
            r_pend_vld   <= w_pend_vld_nxt;
            r_digit_en   <= w_en_nxt;
            r_frame_done <= w_frame_end;
            if (w_state_nxt != ST_SHOW) r_bcd_num <= 4'hF;
            else if (w_digit_entry)     r_bcd_num <= w_disp;
        end
    end

    assign bcd_num    = r_bcd_num;
    assign digit_en   = r_digit_en;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// Bench for bcd_display_scan_ctrl: two instances (with and without guard gap)
// share stimulus; a frame-position reference model predicts each cycle's outputs
// into per-instance queues that a negedge monitor drains and compares.
`timescale 1ns/1ps
module tb_bcd_display_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic        lz;

    logic [3:0] bcd1, bcd0;
    logic [3:0] en1, en0;
    logic       fd1, fd0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] bcd;
        logic       fd;
    } exp_t;

    typedef struct {
        bit          run;
        int          j;      // output cycles since the scan started
        logic [15:0] sh;
        logic [15:0] pd;
        bit          pv;
        logic [3:0]  held;
    } model_t;

    model_t m1, m0;
    exp_t   q1[$];
    exp_t   q0[$];
    exp_t   mon_e;

    always #5 clk = ~clk;

    bcd_display_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
        .lz_suppress(lz), .bcd_num(bcd1), .digit_en(en1), .frame_done(fd1)
    );

    bcd_display_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
        .lz_suppress(lz), .bcd_num(bcd0), .digit_en(en0), .frame_done(fd0)
    );

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Digit d of the shown value: blank when it and everything above it is zero.
    function automatic logic [3:0] disp(input logic [15:0] sh, input int d, input bit lzs);
        logic [15:0] upper;
        upper = sh >> (4 * d);
        if (lzs && d > 0 && upper == 16'h0) return 4'hF;
        return upper[3:0];
    endfunction

    // Reference: outputs derived from position within the frame, j mod (N*(b+R)).
    task automatic model_step(input int b, input bit rst, input bit en, input bit ld, input bit lzs,
                              input logic [15:0] din, inout model_t m, output exp_t e);
        int s, f, p, d, q;
        s = b + R;
        f = N * s;
        e = '{en: 4'h0, bcd: 4'hF, fd: 1'b0};
        if (!rst) begin
            m.run = 0; m.j = 0; m.sh = '0; m.pd = '0; m.pv = 0; m.held = 4'hF;
        end else if (!en) begin
            if (ld) begin
                if (m.run) begin m.pd = din; m.pv = 1; end
                else m.sh = din;
            end
            m.run = 0;
        end else begin
            if (!m.run) begin
                m.run = 1;
                m.j = 0;
                if (ld) m.sh = din;
            end else begin
                m.j++;
                if (m.j % f == 0) begin
                    if (ld) begin m.sh = din; m.pv = 0; end
                    else if (m.pv) begin m.sh = m.pd; m.pv = 0; end
                end else if (ld) begin
                    m.pd = din; m.pv = 1;
                end
            end
            p = m.j % f;
            d = p / s;
            q = p % s;
            e.fd = (m.j > 0 && p == 0);
            if (q >= b) begin
                e.en = 4'(1 << d);
                if (q == b) m.held = disp(m.sh, d, lzs);
                e.bcd = m.held;
            end
        end
    endtask

    // One clock: the DUTs and the model see the same inputs at the edge; inputs move at +1.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step(1, rst_n, enable, load, lz, digits_in, m1, e);
        q1.push_back(e);
        model_step(0, rst_n, enable, load, lz, digits_in, m0, e);
        q0.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        digits_in = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued predictions.
    always @(negedge clk) begin
        if (q1.size() > 0) begin
            mon_e = q1.pop_front();
            check("out_guard1", {en1, bcd1, fd1}, mon_e);
            check("onehot_guard1", 9'($onehot0(en1)), 9'd1);
        end
        if (q0.size() > 0) begin
            mon_e = q0.pop_front();
            check("out_guard0", {en0, bcd0, fd0}, mon_e);
            check("onehot_guard0", 9'($onehot0(en0)), 9'd1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = '0; lz = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(2);

        // Plain scan of 1234 loaded while idle.
        do_load(16'h1234);
        enable = 1'b1;
        run(45);

        // Short reset in the middle of a digit, then restart from digit 0.
        run(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run(25);

        // Leading-zero suppression.
        lz = 1'b1;
        do_load(16'h0050);
        run(45);
        do_load(16'h0000);
        run(45);
        lz = 1'b0;

        // Pending value overwritten before the boundary.
        do_load(16'h9999);
        run(3);
        do_load(16'h8888);
        run(50);

        // Disable while digit 2 is shown, then re-enable.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        run(13);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(25);

        // Load landing exactly on a frame boundary of both instances (cycle 80).
        enable = 1'b0;
        tick();
        enable = 1'b1;
        run(80);
        do_load(16'h4321);
        run(30);

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (enable) enable = ($urandom_range(0, 79) != 0);
            else        enable = ($urandom_range(0, 5) == 0);
            load = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 4; k++)
                v[4*k +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 14));
            digits_in = v;
            if ($urandom_range(0, 49) == 0) lz = ~lz;
            tick();
        end
        rst_n = 1'b1;
        load = 1'b0;
        enable = 1'b0;
        run(3);

        repeat (2) @(negedge clk);
        #1;
        check("drain", 9'(q1.size() + q0.size()), 9'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
